// File: rtl/core_ctrl_fsm_pkg.sv
// core_ctrl_fsm_pkg: decoder constants and control enums shared by the RV32I control sequencer
package core_ctrl_fsm_pkg;
  localparam logic [2:0] INSTR_U   = 3'd0;
  localparam logic [2:0] INSTR_J   = 3'd1;
  localparam logic [2:0] INSTR_I   = 3'd2;
  localparam logic [2:0] INSTR_R   = 3'd3;
  localparam logic [2:0] INSTR_S   = 3'd4;
  localparam logic [2:0] INSTR_B   = 3'd5;
  localparam logic [2:0] INSTR_ERR = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } ctrl_state_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_ALU, PC_RESET, PC_TRAP} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
  typedef enum logic [1:0] {CAUSE_ILLEGAL, CAUSE_ECALL, CAUSE_EBREAK, CAUSE_TIMEOUT} trap_cause_e;

  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                      OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM};
  endfunction
endpackage

// File: rtl/core_ctrl_fsm_mem_timeout_ctr.sv
// core_ctrl_fsm_mem_timeout_ctr: saturating 16-bit wait counter; LIMIT 0 disables the timeout flag
module core_ctrl_fsm_mem_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [15:0] cnt;

  // Count waiting cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != 16'hFFFF) cnt <= cnt + 16'd1;

  // The flag rises during the LIMIT-th waiting cycle so the FSM leaves right after it
  assign timeout = LIMIT > 0 && LIMIT <= 65536 && cnt == 16'(LIMIT - 1);
endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle RV32I control sequencer (optional CORE_CTRL_PERF_CNT_EN adds cycle/instret counters)
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  instr_type,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        ebreak,
  input  logic        branch_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
`ifdef CORE_CTRL_PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);
  ctrl_state_e state;
  trap_cause_e cause;
  logic taken, timeout, busy, illegal;
  logic is_load, is_store, is_branch, is_jump, is_lui, is_sys;

  // The PC reset value lives in the datapath; only its alignment is checked here
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end

  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
  assign is_jump   = opcode == OP_JAL || opcode == OP_JALR;
  assign is_lui    = opcode == OP_LUI;
  assign is_sys    = opcode == OP_SYSTEM;
  // Only ECALL/EBREAK (funct3 0) are handled; CSR accesses are not part of the base ISA here
  assign illegal   = instr_type == INSTR_ERR || !op_legal(opcode) || (is_sys && funct3 != 3'b000);
  assign busy      = state inside {ST_FETCH, ST_MEM};

  core_ctrl_fsm_mem_timeout_ctr #(.LIMIT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!busy),
    .en      (busy),
    .timeout (timeout)
  );

  // Step one instruction at a time; the trap cause and branch outcome are held for TRAP and WB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_RESET;
      cause <= CAUSE_ILLEGAL;
      taken <= 1'b0;
    end else
      case (state)
        ST_RESET: state <= ST_FETCH;
        ST_FETCH, ST_MEM:
          if (mem_ack) state <= state == ST_FETCH ? ST_DECODE : ST_WB;
          else if (timeout) begin
            state <= ST_TRAP;
            cause <= CAUSE_TIMEOUT;
          end
        ST_DECODE:
          if (illegal) begin
            state <= ST_TRAP;
            cause <= CAUSE_ILLEGAL;
          end else state <= ST_EXEC;
        ST_EXEC: begin
          taken <= branch_taken;
          if (is_sys) begin
            state <= ST_TRAP;
            cause <= ebreak ? CAUSE_EBREAK : CAUSE_ECALL;
          end else state <= (is_load || is_store) ? ST_MEM : ST_WB;
        end
        default: state <= ST_FETCH;
      endcase

  // Controls decode from the state register; ir_we alone follows the fetch ack, RESET ones are held off by rst_n
  always_comb begin
    mem_req      = busy;
    mem_we       = state == ST_MEM && is_store;
    mem_addr_sel = state == ST_MEM;
    ir_we        = state == ST_FETCH && mem_ack;
    pc_we        = state inside {ST_WB, ST_TRAP} || (state == ST_RESET && rst_n);
    pc_sel       = state == ST_TRAP ? PC_TRAP :
                   (state == ST_RESET && rst_n) ? PC_RESET :
                   (state == ST_WB && (is_jump || (is_branch && taken))) ? PC_ALU : PC_PLUS4;
    alu_a_sel    = state == ST_EXEC && opcode inside {OP_BRANCH, OP_JAL, OP_AUIPC};
    alu_b_sel    = state == ST_EXEC && opcode inside {OP_OPIMM, OP_LOAD, OP_JALR, OP_STORE,
                                                      OP_BRANCH, OP_JAL, OP_AUIPC};
    rf_we        = state == ST_WB && opcode inside {OP_OP, OP_OPIMM, OP_LOAD, OP_LUI,
                                                    OP_AUIPC, OP_JAL, OP_JALR};
    wb_sel       = state != ST_WB ? WB_ALU : is_load ? WB_MEM : is_jump ? WB_PC4 :
                   is_lui ? WB_IMM : WB_ALU;
    trap         = state == ST_TRAP;
    trap_cause   = state == ST_TRAP ? cause : CAUSE_ILLEGAL;
  end

  assign state_o = state;

`ifdef CORE_CTRL_PERF_CNT_EN
  // Free-running cycle count and retired count; only WB exits retire, trapped instructions never do
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (state == ST_WB) instret_cnt <= instret_cnt + 64'd1;
    end
`endif
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: randomized and directed checks of core_ctrl_fsm against a per-instruction phase model
module tb_core_ctrl_fsm;
  localparam int TO = 16;
  localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63,
                         LD = 7'h03, STO = 7'h23, OPI = 7'h13, OPR = 7'h33, FEN = 7'h0F, SYS = 7'h73;
  localparam logic [2:0] T_ERR = 3'd7;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] instr_type = '0, funct3 = '0;
  logic [6:0] opcode = '0;
  logic ebreak = 1'b0, branch_taken = 1'b0, mem_ack = 1'b0;
  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, trap;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [2:0] state_o;
`ifdef CORE_CTRL_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
  longint cyc = 0, retired = 0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic req, we, asel, irwe, pcwe;
    logic [1:0] pcsel;
    logic a, b, rf;
    logic [1:0] wb;
    logic trap;
    logic [1:0] cause;
  } outs_t;
  typedef struct packed {logic ack; logic bt; outs_t o;} slot_t;

  slot_t tr[$];
  outs_t seen[$];
  outs_t obs, want;
  int checks = 0, errors = 0;
  logic [6:0] ops[14] = '{LUI, AUIPC, JAL, JALR, BR, LD, STO, OPI, OPR, FEN, SYS, 7'h7F, 7'h00, 7'h5B};

  assign obs = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                alu_a_sel, alu_b_sel, rf_we, wb_sel, trap, trap_cause};

  core_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr_type(instr_type), .opcode(opcode), .funct3(funct3),
    .ebreak(ebreak), .branch_taken(branch_taken), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
`ifdef CORE_CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  function automatic outs_t o_of(input logic [2:0] st);
    outs_t o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
`ifdef CORE_CTRL_PERF_CNT_EN
    cyc++;
`endif
  endtask

  task automatic push(input outs_t o, input logic ack, input logic bt);
    slot_t s;
    s.o = o;
    s.ack = ack;
    s.bt = bt;
    tr.push_back(s);
  endtask

  task automatic push_trap(input logic [1:0] c);
    outs_t o = o_of(S_TRAP);
    o.pcwe = 1'b1;
    o.pcsel = 2'd3;
    o.trap = 1'b1;
    o.cause = c;
    push(o, rb(), rb());
  endtask

  // Expected per-cycle trace for the instruction currently on the decoder inputs:
  // fd/md are the cycle in which the fetch/data ack arrives (beyond TO means never)
  task automatic build(input int fd, input int md, input logic tk);
    outs_t o;
    logic legal, a, b, rfw, mem, jmp;
    logic [1:0] wbs;
    tr = {};
    for (int k = 1; k <= fd && k <= TO; k++) begin
      o = o_of(S_FETCH);
      o.req = 1'b1;
      o.irwe = k == fd;
      push(o, k == fd, rb());
    end
    if (fd > TO) begin
      push_trap(2'd3);
      return;
    end
    push(o_of(S_DECODE), rb(), rb());
    legal = 1'b1; a = 1'b0; b = 1'b0; rfw = 1'b0; mem = 1'b0; jmp = 1'b0; wbs = 2'd0;
    case (opcode)
      OPR:      rfw = 1'b1;
      OPI:      begin b = 1'b1; rfw = 1'b1; end
      LD:       begin b = 1'b1; rfw = 1'b1; wbs = 2'd1; mem = 1'b1; end
      JALR:     begin b = 1'b1; rfw = 1'b1; wbs = 2'd2; jmp = 1'b1; end
      STO:      begin b = 1'b1; mem = 1'b1; end
      BR:       begin a = 1'b1; b = 1'b1; jmp = tk; end
      JAL:      begin a = 1'b1; b = 1'b1; rfw = 1'b1; wbs = 2'd2; jmp = 1'b1; end
      AUIPC:    begin a = 1'b1; b = 1'b1; rfw = 1'b1; end
      LUI:      begin rfw = 1'b1; wbs = 2'd3; end
      FEN, SYS: ;
      default:  legal = 1'b0;
    endcase
    if (!legal || instr_type == T_ERR) begin
      push_trap(2'd0);
      return;
    end
    o = o_of(S_EXEC);
    o.a = a;
    o.b = b;
    push(o, rb(), tk);
    if (opcode == SYS) begin
      push_trap(ebreak ? 2'd2 : 2'd1);
      return;
    end
    if (mem) begin
      for (int k = 1; k <= md && k <= TO; k++) begin
        o = o_of(S_MEM);
        o.req = 1'b1;
        o.asel = 1'b1;
        o.we = opcode == STO;
        push(o, k == md, rb());
      end
      if (md > TO) begin
        push_trap(2'd3);
        return;
      end
    end
    o = o_of(S_WB);
    o.pcwe = 1'b1;
    o.pcsel = {1'b0, jmp};
    o.rf = rfw;
    o.wb = wbs;
    push(o, rb(), rb());
`ifdef CORE_CTRL_PERF_CNT_EN
    retired++;
`endif
  endtask

  task automatic play();
    seen = {};
    foreach (tr[i]) begin
      mem_ack = tr[i].ack;
      branch_taken = tr[i].bt;
      @(negedge clk);
      seen.push_back(obs);
      tick();
    end
    mem_ack = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] it, input logic [2:0] f3, input logic eb);
    opcode = op;
    instr_type = it;
    funct3 = f3;
    ebreak = eb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_hold: got %h want 0", obs);
      end
    end
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    rst_n = 1'b1;
`ifdef CORE_CTRL_PERF_CNT_EN
    cyc = 0;
    retired = 0;
`endif
    @(negedge clk);
    want = o_of(S_RESET);
    want.pcwe = 1'b1;
    want.pcsel = 2'd2;
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL reset_cycle: got %h want %h", obs, want);
    end
    tick();
  endtask

  task automatic test_add();
    set_instr(OPR, 3'd3, 3'd0, 1'b0);
    build(2, 0, 1'b0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (seen[i] !== tr[i].o) begin
        errors++;
        $display("FAIL add slot %0d: got %h want %h", i, seen[i], tr[i].o);
      end
    end
  endtask

  task automatic test_load();
    set_instr(LD, 3'd2, 3'd2, 1'b0);
    build(1, 3, 1'b0);
    play();
    foreach (tr[i]) begin
      checks++;
      if (seen[i] !== tr[i].o) begin
        errors++;
        $display("FAIL load slot %0d: got %h want %h", i, seen[i], tr[i].o);
      end
    end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      set_instr(BR, 3'd5, 3'd0, 1'b0);
      build(2, 0, t[0]);
      play();
      foreach (tr[i]) begin
        checks++;
        if (seen[i] !== tr[i].o) begin
          errors++;
          $display("FAIL branch_taken%0d slot %0d: got %h want %h", t, i, seen[i], tr[i].o);
        end
      end
    end
  endtask

  task automatic test_traps();
    for (int t = 0; t < 3; t++) begin
      if (t == 0) set_instr(SYS, 3'd2, 3'd0, 1'b1);
      else if (t == 1) set_instr(SYS, 3'd2, 3'd0, 1'b0);
      else set_instr(7'h7F, T_ERR, 3'd7, 1'b1);
      build(1, 0, 1'b0);
      play();
      foreach (tr[i]) begin
        checks++;
        if (seen[i] !== tr[i].o) begin
          errors++;
          $display("FAIL trap%0d slot %0d: got %h want %h", t, i, seen[i], tr[i].o);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int fd[4] = '{20, 16, 1, 1};
    int md[4] = '{0, 0, 17, 16};
    for (int t = 0; t < 4; t++) begin
      if (t < 2) set_instr(OPR, 3'd3, 3'd0, 1'b0);
      else if (t == 2) set_instr(LD, 3'd2, 3'd2, 1'b0);
      else set_instr(STO, 3'd4, 3'd2, 1'b0);
      build(fd[t], md[t], 1'b0);
      play();
      foreach (tr[i]) begin
        checks++;
        if (seen[i] !== tr[i].o) begin
          errors++;
          $display("FAIL timeout%0d slot %0d: got %h want %h", t, i, seen[i], tr[i].o);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] op;
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(13, 0)];
      set_instr(op, ($urandom % 12 == 0) ? T_ERR : 3'($urandom_range(5, 0)),
                op == SYS ? 3'd0 : 3'($urandom), rb());
      build($urandom_range(4, 1), $urandom_range(4, 1), rb());
      play();
      foreach (tr[i]) begin
        checks++;
        if (seen[i] !== tr[i].o) begin
          errors++;
          $display("FAIL random op=%h slot %0d: got %h want %h", op, i, seen[i], tr[i].o);
        end
      end
    end
  endtask

`ifdef CORE_CTRL_PERF_CNT_EN
  task automatic test_perf_counters();
    @(negedge clk);
    checks++;
    if (cycle_cnt !== 64'(cyc)) begin
      errors++;
      $display("FAIL cycle_cnt: got %0d want %0d", cycle_cnt, cyc);
    end
    checks++;
    if (instret_cnt !== 64'(retired)) begin
      errors++;
      $display("FAIL instret_cnt: got %0d want %0d", instret_cnt, retired);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_mem();
    set_instr(STO, 3'd4, 3'd2, 1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (state_o !== S_MEM || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_setup: got state %0d req %b we %b want 4 1 1", state_o, mem_req, mem_we);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_mem_reset: got %h want 0", obs);
    end
`ifdef CORE_CTRL_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
      errors++;
      $display("FAIL perf_reset: got %0d %0d want 0 0", cycle_cnt, instret_cnt);
    end
`endif
    test_reset();
    test_add();
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_traps();
    test_timeout();
    test_random();
`ifdef CORE_CTRL_PERF_CNT_EN
    test_perf_counters();
`endif
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
